// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one synchronous memory between the core (C) and debug (D) ports,
// tracking read latency and routing read data back to the issuing port.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = $clog2(RD_LAT + 1);
    typedef enum logic {S_READY, S_WAIT} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_prio;
    logic          r_own;
    logic          r_rv;
    logic          w_ready;
    logic          w_gc;
    logic          w_gd;
    logic          w_gnt;
    logic          w_we;
    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        w_ready = (r_state == S_READY) && !rst;
        w_gc    = w_ready && c_req && !(d_req && r_prio);
        w_gd    = w_ready && d_req && !(c_req && !r_prio);
        w_gnt   = w_gc || w_gd;
        w_we    = w_gd ? d_we : c_we;
    end
    assign c_gnt     = w_gc;
    assign d_gnt     = w_gd;
    assign mem_addr  = w_gc ? c_addr : w_gd ? d_addr : '0;
    assign mem_wdata = w_gc ? c_wdata : w_gd ? d_wdata : '0;
    assign mem_we    = w_gnt && w_we;
    assign mem_re    = w_gnt && !w_we;
    assign busy      = r_state == S_WAIT;
    assign c_rvalid  = r_rv && !r_own;
    assign d_rvalid  = r_rv && r_own;
    assign c_rdata   = c_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_prio  <= 1'b0;
            r_own   <= 1'b0;
            r_rv    <= 1'b0;
        end else begin
            r_rv <= (r_state == S_WAIT && r_cnt == CW'(1)) || (RD_LAT == 1 && mem_re);
            if (w_gnt)
                r_prio <= w_gc;
            if (mem_re)
                r_own <= w_gd;
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1))
                    r_state <= S_READY;
            end else if (mem_re && RD_LAT > 1) begin
                r_state <= S_WAIT;
                r_cnt   <= CW'(RD_LAT - 1);
            end
        end
    end
endmodule
